// File: rtl/dsp_mult_buffer.sv
// dsp_mult_buffer
// Operand/result compute buffer for the HPS bridge. The CPU writes packed
// operand words into the operand RAM and pulses start. The block then sends
// words 0..count-1 through a three-stage pipe: address, registered RAM
// output, and registered per-lane products. The products land in the result
// RAM, and the CPU reads them back through the read port.
//
// Lane i of an operand word holds A at [2iW+W-1:2iW] and B at
// [2iW+2W-1:2iW+W], where W = IN_WIDTH. Lane i of a result word holds the
// full 2W-bit product A*B at [2iW+2W-1:2iW].
module dsp_mult_buffer #(
    parameter  int LANES      = 4,
    parameter  int IN_WIDTH   = 16,
    parameter  int ADDR_WIDTH = 6,
    parameter  int SIGNED_MUL = 1,
    localparam int BUS_W      = 2 * LANES * IN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUS_W-1:0]      wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [BUS_W-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [9:0]            leds
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int PROD_W = 2 * IN_WIDTH;

    // The full-RAM word count, at the width of the count port.
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Storage
    logic [BUS_W-1:0]      op_ram  [DEPTH];
    logic [BUS_W-1:0]      res_ram [DEPTH];

    // Control state
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] last_addr_d;
    logic                  addr_vld;

    // Pipe stage 2: registered operand RAM output
    logic [BUS_W-1:0]      op_q;
    logic [ADDR_WIDTH-1:0] op_q_addr;
    logic                  op_q_vld;

    // Pipe stage 3: registered products
    logic [BUS_W-1:0]      prod_d;
    logic [BUS_W-1:0]      prod_q;
    logic [ADDR_WIDTH-1:0] prod_addr;
    logic                  prod_vld;

    // Status
    logic                  done_seen;
    logic                  is_idle;
    logic                  start_ok;
    logic                  start_zero;
    logic                  pipe_empty;
    logic                  run_end;
    logic                  done_set;
    logic                  wr_ok;
    logic                  reject;

    assign is_idle    = (state == ST_IDLE);
    assign start_ok   = is_idle && start && (count != '0);
    assign start_zero = is_idle && start && (count == '0);
    assign pipe_empty = !addr_vld && !op_q_vld && !prod_vld;
    assign run_end    = (state == ST_DRAIN) && pipe_empty;
    assign done_set   = start_zero || run_end;
    assign wr_ok      = is_idle && wr_en;
    assign reject     = !is_idle && (wr_en || start);

    assign busy = !is_idle;
    assign leds = {7'b0, err, done_seen, busy};

    // Compute the last word address. Counts beyond the RAM size are clamped,
    // so the address counter can never wrap.
    // NOTE: give every always_comb output a default first. Any path that
    // leaves the output unassigned would infer a latch.
    always_comb begin
        last_addr_d = '1;
        if (count <= DEPTH_CNT) begin
            last_addr_d = ADDR_WIDTH'(count - 1'b1);
        end
    end

    // Sequencer: accept start in IDLE, issue one address per cycle in RUN,
    // and wait in DRAIN for the pipe to empty.
    // NOTE: all sequential state uses non-blocking assignments, so every
    // register in this file samples values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_addr   <= '0;
            last_addr <= '0;
            addr_vld  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_RUN;
                        op_addr   <= '0;
                        last_addr <= last_addr_d;
                        addr_vld  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (op_addr == last_addr) begin
                        addr_vld <= 1'b0;
                        state    <= ST_DRAIN;
                    end else begin
                        op_addr <= op_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    addr_vld <= 1'b0;
                end
            endcase
        end
    end

    // Operand RAM: the CPU writes it only while idle. The pipe reads it
    // into the stage-2 register.
    // NOTE: the RAM arrays are deliberately left out of reset. This keeps
    // them mappable to block RAM, and their contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            op_ram[wr_addr] <= wr_data;
        end
        if (addr_vld) begin
            op_q <= op_ram[op_addr];
        end
    end

    // Stage-2 and stage-3 valid/address tags. A reset clears these tags at
    // once, which stops any further result writes from an aborted run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q_vld  <= 1'b0;
            op_q_addr <= '0;
            prod_vld  <= 1'b0;
            prod_addr <= '0;
        end else begin
            op_q_vld  <= addr_vld;
            op_q_addr <= op_addr;
            prod_vld  <= op_q_vld;
            prod_addr <= op_q_addr;
        end
    end

    // Per-lane multipliers. Each operand is extended to the product width,
    // so a plain truncated multiply gives the exact full-width product.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IN_WIDTH-1:0] a;
        logic [IN_WIDTH-1:0] b;
        logic [PROD_W-1:0]   ext_a;
        logic [PROD_W-1:0]   ext_b;

        assign a = op_q[2*i*IN_WIDTH +: IN_WIDTH];
        assign b = op_q[2*i*IN_WIDTH + IN_WIDTH +: IN_WIDTH];

        if (SIGNED_MUL != 0) begin : g_signed
            assign ext_a = {{IN_WIDTH{a[IN_WIDTH-1]}}, a};
            assign ext_b = {{IN_WIDTH{b[IN_WIDTH-1]}}, b};
        end else begin : g_unsigned
            assign ext_a = {{IN_WIDTH{1'b0}}, a};
            assign ext_b = {{IN_WIDTH{1'b0}}, b};
        end

        assign prod_d[i*PROD_W +: PROD_W] = ext_a * ext_b;
    end

    // Stage-3 product register
    always_ff @(posedge clk) begin
        if (op_q_vld) begin
            prod_q <= prod_d;
        end
    end

    // Result RAM write from the product stage
    always_ff @(posedge clk) begin
        if (prod_vld) begin
            res_ram[prod_addr] <= prod_q;
        end
    end

    // CPU read port: the read is registered, with one cycle of latency.
    // rd_data holds its value between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= res_ram[rd_addr];
            end
        end
    end

    // Status flags. A completion that lands on the same edge as an accepted
    // start (a count=0 start) leaves done_seen set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done      <= 1'b0;
            done_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= done_set;
            if (done_set) begin
                done_seen <= 1'b1;
            end else if (start_ok) begin
                done_seen <= 1'b0;
            end
            if (reject) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mult_buffer.sv
// tb_dsp_mult_buffer
// Randomised bench with a behavioural model of both RAMs. Reads push the
// model's expected word into a queue, and a monitor process compares each
// rd_valid word against the head of that queue.
module tb_dsp_mult_buffer;

    localparam int LANES = 4;
    localparam int IN_W  = 16;
    localparam int AW    = 6;
    localparam int BUS_W = 2 * LANES * IN_W;
    localparam int DEPTH = 2 ** AW;

    logic             clk;
    logic             reset_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [BUS_W-1:0] wr_data;
    logic             start;
    logic [AW:0]      count;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [BUS_W-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [9:0]       leds;

    logic [BUS_W-1:0] rd_data_u;
    logic             rd_valid_u;
    logic             busy_u;
    logic             done_u;
    logic             err_u;
    logic [9:0]       leds_u;

    int checks = 0;
    int errors = 0;

    logic [BUS_W-1:0] op_mem  [DEPTH];
    logic [BUS_W-1:0] res_mem [DEPTH];
    logic [BUS_W-1:0] exp_q   [$];

    dsp_mult_buffer #(.LANES(LANES), .IN_WIDTH(IN_W), .ADDR_WIDTH(AW), .SIGNED_MUL(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .count(count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err), .leds(leds)
    );

    dsp_mult_buffer #(.LANES(LANES), .IN_WIDTH(IN_W), .ADDR_WIDTH(AW), .SIGNED_MUL(0)) u_dut_u (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .count(count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_u),
        .rd_valid(rd_valid_u), .busy(busy_u), .done(done_u), .err(err_u), .leds(leds_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: each lane is an integer product, taken modulo 2^32.
    function automatic logic [BUS_W-1:0] model_mul(input logic [BUS_W-1:0] w, input bit sgn);
        logic [BUS_W-1:0] r;
        longint a;
        longint b;
        longint p;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sgn) begin
                a = longint'($signed(w[32*i +: 16]));
                b = longint'($signed(w[32*i+16 +: 16]));
            end else begin
                a = longint'(w[32*i +: 16]);
                b = longint'(w[32*i+16 +: 16]);
            end
            p = a * b;
            r[32*i +: 32] = p[31:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [BUS_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        op_mem[a] = d;
    endtask

    task automatic read_word(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        exp_q.push_back(res_mem[a]);
        tick();
        rd_en = 1'b0;
    endtask

    // Run one compute pass. inj > 0 issues a write plus a second start in
    // that cycle. abt > 0 asserts reset in that cycle.
    task automatic run(input int n, input int inj, input int abt);
        int busy_cnt;
        int done_cnt;
        int done_cyc;
        int upto;
        start = 1'b1;
        count = (AW + 1)'(n);
        tick();
        start    = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= n + 8; cyc++) begin
            if (abt != 0 && cyc == abt) begin
                reset_n = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (inj != 0 && cyc == inj) begin
                wr_en   = 1'b1;
                wr_addr = 6'd3;
                wr_data = {$urandom, $urandom, $urandom, $urandom};
                start   = 1'b1;
                count   = 7'd5;
            end
            tick();
            wr_en = 1'b0;
            start = 1'b0;
        end
        if (abt != 0) begin
            check("abort_no_done", done_cnt, 0);
            reset_n = 1'b1;
            tick();
            upto = abt - 3;
        end else begin
            check("done_cycle", done_cyc, (n == 0) ? 1 : n + 4);
            check("busy_cycles", busy_cnt, (n == 0) ? 0 : n + 3);
            check("done_pulses", done_cnt, 1);
            upto = n;
        end
        for (int k = 0; k < upto; k++) res_mem[k] = model_mul(op_mem[k], 1'b1);
    endtask

    // Scoreboard monitor
    initial begin
        logic [BUS_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        count   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_leds", leds, 0);
        reset_n = 1'b1;
        tick();

        // 1: 3*5 in every lane, count=1
        write_word(0, {4{16'd5, 16'd3}});
        run(1, 0, 0);
        read_word(0);
        check("leds_done_seen", leds, 10'b0000000010);

        // 2: -1*2 signed and unsigned
        write_word(1, {4{16'h0002, 16'hFFFF}});
        run(2, 0, 0);
        read_word(1);
        check("unsigned_lane0", rd_data_u[31:0], 32'h0001FFFE);
        check("unsigned_lane3", rd_data_u[127:96], 32'h0001FFFE);

        // 3: full RAM, A=k, B=k+1
        for (int k = 0; k < DEPTH; k++) write_word(k, {4{16'(k + 1), 16'(k)}});
        run(DEPTH, 0, 0);
        for (int k = 0; k < DEPTH; k++) read_word(k);
        check("model_word63", res_mem[63][31:0], 32'd4032);

        // 4: count=0 leaves results untouched
        run(0, 0, 0);
        read_word(0);
        read_word(63);

        // 5: write and start during RUN are dropped
        for (int k = 0; k < 20; k++) write_word(k, {$urandom, $urandom, $urandom, $urandom});
        run(20, 5, 0);
        check("err_set", err, 1);
        check("leds_err", leds[2], 1);
        for (int k = 0; k < 20; k++) read_word(k);

        // 6: reset in cycle 10 of a count=20 run
        for (int k = 0; k < 20; k++) write_word(k, {$urandom, $urandom, $urandom, $urandom});
        run(20, 0, 10);
        check("post_abort_leds", leds, 0);
        for (int k = 0; k < 20; k++) read_word(k);

        // Random traffic
        for (int it = 0; it < 5; it++) begin
            int nw;
            int n;
            nw = int'($urandom_range(1, 16));
            for (int j = 0; j < nw; j++)
                write_word(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom, $urandom, $urandom});
            n = int'($urandom_range(1, DEPTH));
            run(n, 0, 0);
            for (int j = 0; j < 8; j++) read_word(int'($urandom_range(0, DEPTH - 1)));
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
